// File: rtl/corelet_seq_ctrl_pkg.sv
// Shared opcodes, mode encodings and FSM state type for the corelet sequencer.
package corelet_pkg;

    localparam int unsigned OP_BW = 16;

    localparam logic [OP_BW-1:0] OP_NOP   = 16'd0;
    localparam logic [OP_BW-1:0] OP_LOADW = 16'd1;
    localparam logic [OP_BW-1:0] OP_EXEC  = 16'd2;

    localparam logic MODE_4B = 1'b0;
    localparam logic MODE_2B = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_W,
        S_LOAD_W,
        S_FETCH_A,
        S_DRAIN,
        S_DONE
    } state_e;

    // The SIMD flag rides in bit 2 of every non-NOP instruction word.
    function automatic logic [OP_BW-1:0] make_inst(input logic [OP_BW-1:0] op, input logic m);
        make_inst = op | ((m == MODE_2B) ? OP_BW'(4) : '0);
    endfunction

endpackage

// File: rtl/corelet_seq_ctrl_skew_pipe.sv
// Free-running shift register: bit 0 follows the input by one cycle, bit i by i+1 cycles.
module skew_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;

    assign sh_d = WIDTH'({sh_q, in_i});
    assign q_o  = sh_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

endmodule

// File: rtl/corelet_seq_ctrl.sv
// Corelet job sequencer: weight fetch, weight load, activation streaming and drain
// for one L0 -> MAC array -> OFIFO slice, with row and column skew pipelines.
module corelet_seq_ctrl
    import corelet_pkg::*;
#(
    parameter int unsigned ROWS    = 8,
    parameter int unsigned COLS    = 8,
    parameter int unsigned INST_BW = 16,
    parameter int unsigned W_WORDS = 8,
    parameter int unsigned CNT_BW  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    mode,
    input  logic [CNT_BW-1:0]       n_act,
    output logic                    req_w,
    input  logic                    ack_w,
    output logic                    req_a,
    input  logic                    ack_a,
    input  logic                    ofifo_full,
    output logic                    l0_wr,
    output logic [ROWS-1:0]         l0_rd,
    output logic [ROWS*INST_BW-1:0] ii_w,
    output logic [COLS-1:0]         ofifo_wr,
    output logic                    busy,
    output logic                    done
);

    state_e              state_q, state_d;
    logic [CNT_BW-1:0]   cnt_q, cnt_d;
    logic [CNT_BW-1:0]   a_cnt_q, a_cnt_d;
    logic [CNT_BW-1:0]   n_act_q, n_act_d;
    logic                mode_q, mode_d;
    logic                req_a_q, req_a_d;
    logic                act_acc;
    logic [ROWS-1:0]     row_sk;
    logic [COLS-1:0]     col_sk;
    logic [INST_BW-1:0]  load_word, exec_word;

    // Acceptance ignores req_a so words already in flight when it drops are kept.
    assign act_acc   = ack_a && (state_q == S_FETCH_A);
    assign load_word = INST_BW'(make_inst(OP_LOADW, mode_q));
    assign exec_word = INST_BW'(make_inst(OP_EXEC, mode_q));

    skew_pipe #(.WIDTH(ROWS)) u_row_skew (
        .clk   (clk),
        .reset (reset),
        .in_i  (act_acc),
        .q_o   (row_sk)
    );

    skew_pipe #(.WIDTH(COLS)) u_col_skew (
        .clk   (clk),
        .reset (reset),
        .in_i  (row_sk[ROWS-1]),
        .q_o   (col_sk)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_cnt_d = a_cnt_q;
        n_act_d = n_act_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH_W;
                    cnt_d   = '0;
                    a_cnt_d = '0;
                    n_act_d = n_act;
                    mode_d  = mode;
                end
            end
            S_FETCH_W: begin
                if (ack_w) begin
                    if (cnt_q == CNT_BW'(W_WORDS - 1)) begin
                        state_d = S_LOAD_W;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_BW'(1);
                    end
                end
            end
            S_LOAD_W: begin
                if (cnt_q == CNT_BW'(W_WORDS - 1)) begin
                    cnt_d   = '0;
                    state_d = (n_act_q == '0) ? S_DONE : S_FETCH_A;
                end else begin
                    cnt_d = cnt_q + CNT_BW'(1);
                end
            end
            S_FETCH_A: begin
                if (act_acc && (a_cnt_q != n_act_q)) begin
                    a_cnt_d = a_cnt_q + CNT_BW'(1);
                    if (a_cnt_d == n_act_q) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_BW'(ROWS + COLS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_BW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_a_d = (state_d == S_FETCH_A) && !ofifo_full;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_cnt_q <= '0;
            n_act_q <= '0;
            mode_q  <= MODE_4B;
            req_a_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_cnt_q <= a_cnt_d;
            n_act_q <= n_act_d;
            mode_q  <= mode_d;
            req_a_q <= req_a_d;
        end
    end

    always_comb begin
        req_w    = (state_q == S_FETCH_W);
        req_a    = req_a_q;
        l0_wr    = ((state_q == S_FETCH_W) && ack_w) || act_acc;
        l0_rd    = (state_q == S_LOAD_W) ? '1 : row_sk;
        ofifo_wr = col_sk;
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        ii_w     = '0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (state_q == S_LOAD_W) begin
                ii_w[i*INST_BW +: INST_BW] = load_word;
            end else if (row_sk[i]) begin
                ii_w[i*INST_BW +: INST_BW] = exec_word;
            end else begin
                ii_w[i*INST_BW +: INST_BW] = INST_BW'(OP_NOP);
            end
        end
    end

endmodule
